// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle between the core and the multiply/divide unit
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        input  req_ready, resp_valid, resp_result
    );
    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV-M unit, fixed-latency multiply and 1-bit/cycle restoring divide
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, res_q, res_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [1:0]      m_op;
    logic [XLEN-1:0] m_a, m_b, mul_res;
    logic [2*XLEN-1:0] m_ea, m_eb, prod;
    logic [XLEN:0]   shl, diff;
    logic            r_sgn, s1, s2, dz, ovf;
    // A single-cycle multiply must take its operands straight from the request
    assign m_op    = state_q == IDLE ? bus.req_op[1:0] : op_q;
    assign m_a     = state_q == IDLE ? bus.req_rs1 : a_q;
    assign m_b     = state_q == IDLE ? bus.req_rs2 : b_q;
    assign m_ea    = {{XLEN{(m_op == 2'd1 || m_op == 2'd2) & m_a[XLEN-1]}}, m_a};
    assign m_eb    = {{XLEN{(m_op == 2'd1) & m_b[XLEN-1]}}, m_b};
    assign prod    = m_ea * m_eb;
    assign mul_res = m_op == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    // Restoring step: a_q shifts the dividend out and the quotient in
    assign shl  = {rem_q, a_q[XLEN-1]};
    assign diff = shl - {1'b0, b_q};
    assign r_sgn = ~bus.req_op[0];
    assign s1    = r_sgn & bus.req_rs1[XLEN-1];
    assign s2    = r_sgn & bus.req_rs2[XLEN-1];
    assign dz    = bus.req_rs2 == '0;
    assign ovf   = r_sgn && bus.req_rs1 == {1'b1, {(XLEN-1){1'b0}}} && &bus.req_rs2;
    assign bus.req_ready   = state_q == IDLE;
    assign bus.resp_valid  = state_q == DONE;
    assign bus.resp_result = res_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (bus.flush)
            state_d = IDLE;
        else
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    op_d = bus.req_op[1:0];
                    a_d  = bus.req_rs1;
                    b_d  = bus.req_rs2;
                    if (!bus.req_op[2]) begin
                        if (MUL_LATENCY == 1) begin
                            state_d = DONE;
                            res_d   = mul_res;
                        end else begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_LATENCY - 1);
                        end
                    end else if (dz) begin
                        state_d = DONE;
                        res_d   = bus.req_op[1] ? bus.req_rs1 : '1;
                    end else if (ovf) begin
                        state_d = DONE;
                        res_d   = bus.req_op[1] ? '0 : bus.req_rs1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CW'(XLEN - 1);
                        a_d     = s1 ? -bus.req_rs1 : bus.req_rs1;
                        b_d     = s2 ? -bus.req_rs2 : bus.req_rs2;
                        rem_d   = '0;
                        qneg_d  = s1 ^ s2;
                        rneg_d  = s1;
                    end
                end
                MUL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        res_d   = mul_res;
                    end
                end
                DIV: begin
                    rem_d   = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
                    a_d     = {a_q[XLEN-2:0], ~diff[XLEN]};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? FIX : DIV;
                end
                FIX: begin
                    state_d = DONE;
                    res_d   = op_q[1] ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -a_q : a_q);
                end
                DONE: state_d = bus.resp_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV-M execution unit. Replaces the single-cycle combinational multiply/divide path in the ALU with a valid/ready request/response block.
- Multiply uses a fixed-latency registered pipeline shift; divide uses an iterative restoring divider at 1 quotient bit/cycle.
- Divide-by-zero and signed overflow take a 1-cycle early-out.
- The core stalls on req_ready and resp_valid and can flush an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_LATENCY, 3, cycles from accept to resp_valid for multiplies; legal range 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_rs1  in  XLEN  operand A (dividend).
- req_rs2  in  XLEN  operand B (divisor).
- flush  in  1  abort the in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_result  out  XLEN  result.

Behaviour:
- Reset (rst high at a clk edge; overrides everything, including mid-operation):
  - state=IDLE, resp_valid=0, resp_result=0, req_ready=1 the cycle after, counters=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: req_valid && req_ready at an edge latches op and operands. That cycle is called T.
  - Inputs are ignored outside IDLE.
  - req_ready is combinational from state only, never from req_valid.
- Multiply (op 0-3):
  - Full 2*XLEN product. Signed, signed×unsigned and unsigned extension are chosen per op.
  - IDLE->MUL; the counter loads MUL_LATENCY-1; at 0 go to DONE.
  - resp_valid first high in cycle T+MUL_LATENCY.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide (op 4-7), early-out cases go directly to DONE, resp_valid high in cycle T+1:
  - rs2==0: DIV/DIVU result all-ones; REM/REMU result = rs1.
  - Signed ops with rs1==MIN_INT (1<<(XLEN-1)) and rs2==all-ones: DIV result = rs1; REM result = 0.
- Divide, normal case:
  - Signed ops convert operands to magnitudes at accept.
  - DIV runs XLEN iterations, restoring: shift remainder in, subtract, set quotient bit.
  - FIX applies signs: quotient negative iff signs differ; remainder takes the dividend's sign.
  - resp_valid first high in cycle T+XLEN+2.
- DONE:
  - resp_valid=1 and resp_result is stable until resp_valid && resp_ready at an edge, then IDLE.
  - Back-to-back: a new request can be accepted no earlier than the cycle after the handshake, since req_ready=0 in DONE.
- Flush:
  - flush high at an edge in MUL/DIV/FIX/DONE forces IDLE and resp_valid=0. No response is produced.
  - In IDLE, flush blocks acceptance that cycle.
  - If flush and the resp handshake coincide, both go to IDLE; the consumer has taken the result.
- resp_result holds its last value when not valid and updates only on the transition into DONE.
- All arithmetic is two's-complement modulo 2^XLEN. No exceptions are raised.

Test Plan:
1. XLEN=32, MUL_LATENCY=3: MUL rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0x00000001 in cycle T+3. MULH same operands -> 0x00000000. MULHU -> 0xFFFFFFFE. MULHSU -> 0xFFFFFFFF.
2. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD in cycle T+34. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
3. Early-outs, each resp_valid in cycle T+1:
   - DIVU x/0 -> 0xFFFFFFFF.
   - REM 0x12345678/0 -> 0x12345678.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM same operands -> 0.
4. Backpressure: hold resp_ready=0 for 5 cycles after a DIV completes -> resp_valid and resp_result stable, req_ready=0. Then resp_ready=1 -> IDLE next cycle, and a queued request is accepted the following cycle.
5. Flush and reset:
   - flush at T+10 of a DIV -> resp_valid never rises, req_ready=1 at T+11.
   - rst at T+5 of a DIV -> all outputs at reset values the next cycle.
6. XLEN=64: DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000. MULHU (2^64-1)^2 -> 0xFFFFFFFFFFFFFFFE. Normal 64-bit DIV latency is T+66.
